// File: rtl/time_of_day_counter.sv
// Time-of-day counter: fraction/seconds/minutes/hours fields plus a flat tick count,
// with load, per-field adjust, 12-hour view and a midnight rollover pulse.
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 100,
  parameter int FRAC_WIDTH    = 7,
  parameter int COUNT_WIDTH   = 24,
  parameter int START_HOURS   = 0,
  parameter int START_MINUTES = 0
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic                   i_Tick,
  input  logic                   i_Minutes_Inc,
  input  logic                   i_Minutes_Dec,
  input  logic                   i_Hours_Inc,
  input  logic                   i_Hours_Dec,
  input  logic                   i_Load,
  input  logic [4:0]             i_Load_Hours,
  input  logic [5:0]             i_Load_Minutes,
  output logic [FRAC_WIDTH-1:0]  o_Fraction,
  output logic [5:0]             o_Seconds,
  output logic [5:0]             o_Minutes,
  output logic [4:0]             o_Hours,
  output logic [3:0]             o_Hours_12,
  output logic                   o_PM,
  output logic [COUNT_WIDTH-1:0] o_Count,
  output logic                   o_Day_Rollover,
  output logic                   o_Load_Error
);

  localparam logic [FRAC_WIDTH-1:0]  FRAC_MAX    = FRAC_WIDTH'(TICKS_PER_SEC - 1);
  localparam logic [COUNT_WIDTH-1:0] MIN_TICKS   = COUNT_WIDTH'(60 * TICKS_PER_SEC);
  localparam logic [COUNT_WIDTH-1:0] HOUR_TICKS  = COUNT_WIDTH'(3600 * TICKS_PER_SEC);
  localparam logic [COUNT_WIDTH-1:0] MIN_WRAP    = COUNT_WIDTH'(59 * 60 * TICKS_PER_SEC);
  localparam logic [COUNT_WIDTH-1:0] HOUR_WRAP   = COUNT_WIDTH'(23 * 3600 * TICKS_PER_SEC);
  localparam logic [COUNT_WIDTH-1:0] START_COUNT =
    COUNT_WIDTH'((START_HOURS * 3600 + START_MINUTES * 60) * TICKS_PER_SEC);

  function automatic logic [3:0] to_12h(input logic [4:0] h);
    if (h == 5'd0)      return 4'd12;
    else if (h > 5'd12) return 4'(h - 5'd12);
    else                return h[3:0];
  endfunction

  logic [FRAC_WIDTH-1:0]  frac_q, frac_d;
  logic [5:0]             sec_q, sec_d;
  logic [5:0]             min_q, min_d;
  logic [4:0]             hr_q, hr_d;
  logic [3:0]             h12_q, h12_d;
  logic                   pm_q, pm_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   roll_q, roll_d;
  logic                   lerr_q, lerr_d;

  logic adjust, min_up, min_dn, hr_up, hr_dn;

  assign adjust = i_Minutes_Inc | i_Minutes_Dec | i_Hours_Inc | i_Hours_Dec;
  assign min_up = i_Minutes_Inc & ~i_Minutes_Dec;
  assign min_dn = i_Minutes_Dec & ~i_Minutes_Inc;
  assign hr_up  = i_Hours_Inc & ~i_Hours_Dec;
  assign hr_dn  = i_Hours_Dec & ~i_Hours_Inc;

  always_comb begin
    frac_d  = frac_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    count_d = count_q;
    roll_d  = 1'b0;
    lerr_d  = 1'b0;
    if (i_Load) begin
      if (i_Load_Hours <= 5'd23 && i_Load_Minutes <= 6'd59) begin
        hr_d    = i_Load_Hours;
        min_d   = i_Load_Minutes;
        sec_d   = 6'd0;
        frac_d  = '0;
        count_d = COUNT_WIDTH'((32'(i_Load_Hours) * 3600 + 32'(i_Load_Minutes) * 60)
                               * TICKS_PER_SEC);
      end else begin
        lerr_d = 1'b1;
      end
    end else if (adjust) begin
      // Each field wraps on its own; o_Count tracks the field change exactly.
      if (min_up) begin
        if (min_q == 6'd59) begin min_d = 6'd0;  count_d = count_d - MIN_WRAP;  end
        else                begin min_d = min_q + 6'd1; count_d = count_d + MIN_TICKS; end
      end else if (min_dn) begin
        if (min_q == 6'd0)  begin min_d = 6'd59; count_d = count_d + MIN_WRAP;  end
        else                begin min_d = min_q - 6'd1; count_d = count_d - MIN_TICKS; end
      end
      if (hr_up) begin
        if (hr_q == 5'd23)  begin hr_d = 5'd0;  count_d = count_d - HOUR_WRAP;  end
        else                begin hr_d = hr_q + 5'd1; count_d = count_d + HOUR_TICKS; end
      end else if (hr_dn) begin
        if (hr_q == 5'd0)   begin hr_d = 5'd23; count_d = count_d + HOUR_WRAP;  end
        else                begin hr_d = hr_q - 5'd1; count_d = count_d - HOUR_TICKS; end
      end
    end else if (i_Enable && i_Tick) begin
      count_d = count_q + COUNT_WIDTH'(1);
      if (frac_q == FRAC_MAX) begin
        frac_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hr_q == 5'd23) begin
              hr_d    = 5'd0;
              count_d = '0;
              roll_d  = 1'b1;
            end else begin
              hr_d = hr_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        frac_d = frac_q + FRAC_WIDTH'(1);
      end
    end
    h12_d = to_12h(hr_d);
    pm_d  = (hr_d >= 5'd12);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      frac_q  <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'(START_MINUTES);
      hr_q    <= 5'(START_HOURS);
      h12_q   <= to_12h(5'(START_HOURS));
      pm_q    <= (START_HOURS >= 12);
      count_q <= START_COUNT;
      roll_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      frac_q  <= frac_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      h12_q   <= h12_d;
      pm_q    <= pm_d;
      count_q <= count_d;
      roll_q  <= roll_d;
      lerr_q  <= lerr_d;
    end
  end

  assign o_Fraction     = frac_q;
  assign o_Seconds      = sec_q;
  assign o_Minutes      = min_q;
  assign o_Hours        = hr_q;
  assign o_Hours_12     = h12_q;
  assign o_PM           = pm_q;
  assign o_Count        = count_q;
  assign o_Day_Rollover = roll_q;
  assign o_Load_Error   = lerr_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: per-cycle expected values are queued at stimulus time
// and compared by an independent monitor; directed constant checks cover key scenarios.
module tb_time_of_day_counter;

  localparam int TPS = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, tk = 1'b0, mi = 1'b0, md = 1'b0, hi = 1'b0, hd = 1'b0, ld = 1'b0;
  logic [4:0]  lh = '0;
  logic [5:0]  lm = '0;
  logic [6:0]  frac;
  logic [5:0]  secs, mins;
  logic [4:0]  hrs;
  logic [3:0]  h12;
  logic        pm, roll, lerr;
  logic [23:0] cnt;

  time_of_day_counter #(
    .TICKS_PER_SEC(TPS), .FRAC_WIDTH(7), .COUNT_WIDTH(24),
    .START_HOURS(7), .START_MINUTES(30)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Tick(tk),
    .i_Minutes_Inc(mi), .i_Minutes_Dec(md), .i_Hours_Inc(hi), .i_Hours_Dec(hd),
    .i_Load(ld), .i_Load_Hours(lh), .i_Load_Minutes(lm),
    .o_Fraction(frac), .o_Seconds(secs), .o_Minutes(mins), .o_Hours(hrs),
    .o_Hours_12(h12), .o_PM(pm), .o_Count(cnt),
    .o_Day_Rollover(roll), .o_Load_Error(lerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frac, secs, mins, hrs, h12, pm, roll, lerr, count;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_hr = 7, m_min = 30, m_sec = 0, m_frac = 0;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: field semantics only; count derived from the fields.
  task automatic model(input logic r, l, input int h, input int m, input logic e, t,
                       input logic a_mi, a_md, a_hi, a_hd);
    exp_t x;
    x.roll = 0;
    x.lerr = 0;
    if (r) begin
      m_hr = 7; m_min = 30; m_sec = 0; m_frac = 0;
    end else if (l) begin
      if (h <= 23 && m <= 59) begin
        m_hr = h; m_min = m; m_sec = 0; m_frac = 0;
      end else x.lerr = 1;
    end else if (a_mi || a_md || a_hi || a_hd) begin
      if (a_mi && !a_md) m_min = (m_min + 1) % 60;
      if (a_md && !a_mi) m_min = (m_min + 59) % 60;
      if (a_hi && !a_hd) m_hr = (m_hr + 1) % 24;
      if (a_hd && !a_hi) m_hr = (m_hr + 23) % 24;
    end else if (e && t) begin
      m_frac++;
      if (m_frac == TPS) begin m_frac = 0; m_sec++; end
      if (m_sec == 60) begin m_sec = 0; m_min++; end
      if (m_min == 60) begin m_min = 0; m_hr++; end
      if (m_hr == 24) begin m_hr = 0; x.roll = 1; end
    end
    x.frac = m_frac; x.secs = m_sec; x.mins = m_min; x.hrs = m_hr;
    x.count = ((m_hr * 60 + m_min) * 60 + m_sec) * TPS + m_frac;
    x.h12 = (m_hr == 0) ? 12 : (m_hr > 12) ? m_hr - 12 : m_hr;
    x.pm = (m_hr >= 12) ? 1 : 0;
    sb.push_back(x);
  endtask

  task automatic step(input logic r, l, input int h, input int m, input logic e, t,
                      input logic a_mi, a_md, a_hi, a_hd);
    @(negedge clk);
    rst = r; ld = l; lh = 5'(h); lm = 6'(m); en = e; tk = t;
    mi = a_mi; md = a_md; hi = a_hi; hd = a_hd;
    model(r, l, h, m, e, t, a_mi, a_md, a_hi, a_hd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                       step(0,0,0,0,0,0,0,0,0,0); endtask
  task automatic load(input int h, input int m); step(0,1,h,m,0,0,0,0,0,0); endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,1,1,0,0,0,0);
  endtask

  // Monitor: every cycle with a queued expectation is compared field by field.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp("sb_count", int'(cnt), x.count);
        cmp("sb_hours", int'(hrs), x.hrs);
        cmp("sb_minutes", int'(mins), x.mins);
        cmp("sb_seconds", int'(secs), x.secs);
        cmp("sb_fraction", int'(frac), x.frac);
        cmp("sb_hours12", int'(h12), x.h12);
        cmp("sb_pm", int'(pm), x.pm);
        cmp("sb_rollover", int'(roll), x.roll);
        cmp("sb_load_error", int'(lerr), x.lerr);
      end
    end
  end

  initial begin
    step(1,0,0,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0,0);
    cmp("reset_hours", int'(hrs), 7);
    cmp("reset_minutes", int'(mins), 30);
    cmp("reset_count", int'(cnt), 2700000);
    cmp("reset_h12", int'(h12), 7);
    cmp("reset_pm", int'(pm), 0);

    load(23, 59);
    cmp("load2359_count", int'(cnt), 8634000);
    ticks(5999);
    cmp("pre_roll_count", int'(cnt), 8639999);
    cmp("pre_roll_flag", int'(roll), 0);
    ticks(1);
    cmp("roll_count", int'(cnt), 0);
    cmp("roll_hours", int'(hrs), 0);
    cmp("roll_flag", int'(roll), 1);
    idle();
    cmp("roll_pulse_end", int'(roll), 0);

    load(10, 59);
    ticks(3000);
    cmp("at_105930_count", int'(cnt), 3957000);
    step(0,0,0,0,0,0,1,0,0,0);
    cmp("min_wrap_hours", int'(hrs), 10);
    cmp("min_wrap_minutes", int'(mins), 0);
    cmp("min_wrap_seconds", int'(secs), 30);
    cmp("min_wrap_count", int'(cnt), 3603000);

    load(0, 15);
    step(0,0,0,0,0,0,0,0,0,1);
    cmp("hdec_hours", int'(hrs), 23);
    cmp("hdec_h12", int'(h12), 11);
    cmp("hdec_pm", int'(pm), 1);
    cmp("hdec_count", int'(cnt), 8370000);

    step(0,0,0,0,1,1,1,1,0,0);
    cmp("inc_dec_tick_count", int'(cnt), 8370000);
    step(0,0,0,0,0,1,0,0,0,0);
    cmp("tick_disabled_count", int'(cnt), 8370000);

    load(24, 0);
    cmp("bad_hours_err", int'(lerr), 1);
    cmp("bad_hours_count", int'(cnt), 8370000);
    load(12, 60);
    cmp("bad_minutes_err", int'(lerr), 1);
    idle();
    cmp("load_err_pulse_end", int'(lerr), 0);
    load(12, 0);
    cmp("noon_h12", int'(h12), 12);
    cmp("noon_pm", int'(pm), 1);
    cmp("noon_count", int'(cnt), 4320000);

    step(0,0,0,0,0,0,1,0,1,0);
    cmp("both_inc_count", int'(cnt), 4686000);
    cmp("both_inc_h12", int'(h12), 1);
    load(0, 0);
    step(0,0,0,0,0,0,0,1,0,1);
    cmp("both_dec_wrap_count", int'(cnt), 8634000);
    step(0,0,0,0,0,0,1,0,1,1);
    cmp("min_wrap_hr_hold_count", int'(cnt), 8280000);

    step(1,1,3,4,1,1,0,0,0,0);
    cmp("reset_wins_count", int'(cnt), 2700000);
    cmp("reset_wins_minutes", int'(mins), 30);

    load(23, 58);
    for (int i = 0; i < 400; i++) begin
      int p;
      p = int'($urandom_range(0, 99));
      step(p == 0,
           $urandom_range(0, 99) < 4,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
    end

    idle();
    repeat (2) @(posedge clk);
    #3;
    cmp("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
